// File: rtl/raster_stream_gen_pkg.sv
// Shared widths and FSM encoding for the raster stream generator.
package raster_stream_gen_pkg;
  localparam int PIX_W   = 11;
  localparam int COORD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/raster_counter.sv
// Raster-order fetch address counters (X fastest) with first-of-frame,
// first-of-line and last-pixel flags decoded from the current address.
module raster_counter
  import raster_stream_gen_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               first_frame,
  output logic               first_line,
  output logic               last_pix
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_LAST);
  assign y_end = (y == Y_LAST);

  // Wrapping to (0,0) after the last pixel leaves the counter ready for the next frame.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

  assign first_frame = (x == '0) && (y == '0);
  assign first_line  = (x == '0) && (y != '0);
  assign last_pix    = x_end && y_end;
endmodule

// File: rtl/raster_stream_gen.sv
// Raster pixel streamer: fetches a WIDTH x HEIGHT buffer in raster order and emits it 2 cycles later.
// Optional RASTER_TESTPAT_EN adds TestMode, replacing buffer data with {Y[2:0], X} and idling RdEn.
module raster_stream_gen
  import raster_stream_gen_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic               Continuous,
`ifdef RASTER_TESTPAT_EN
  input  logic               TestMode,
`endif
  output logic               Busy,
  output logic               Done,
  output logic               RdEn,
  output logic [COORD_W-1:0] RdX,
  output logic [COORD_W-1:0] RdY,
  input  logic [PIX_W-1:0]   RdData,
  output logic [PIX_W-1:0]   Pixel,
  output logic               Frame,
  output logic               Line,
  output logic               PixValid
);
  state_t             state;
  state_t             state_nxt;
  logic               scan;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               first_frame;
  logic               first_line;
  logic               last_pix;
  logic               v1;
  logic               f1;
  logic               l1;
  logic               d1;
  logic [PIX_W-1:0]   pix_src;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_counter (
    .Clk         (Clk),
    .nReset      (nReset),
    .advance     (scan),
    .x           (x),
    .y           (y),
    .first_frame (first_frame),
    .first_line  (first_line),
    .last_pix    (last_pix)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // A new frame is only accepted once the previous one has fully drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start && !v1 && !PixValid) state_nxt = SCAN;
      SCAN:    if (last_pix && !Continuous)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign scan = (state == SCAN);
  assign RdX  = x;
  assign RdY  = y;
  assign Busy = scan || v1 || PixValid;

`ifdef RASTER_TESTPAT_EN
  logic             m1;
  logic [PIX_W-1:0] tp1;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      m1  <= 1'b0;
      tp1 <= '0;
    end else begin
      m1  <= scan && TestMode;
      tp1 <= {y[2:0], x};
    end
  end

  assign RdEn    = scan && !TestMode;
  assign pix_src = m1 ? tp1 : RdData;
`else
  assign RdEn    = scan;
  assign pix_src = RdData;
`endif

  // Stage 1 tracks the fetch in flight; stage 2 is the output register aligned with RdData.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      v1       <= 1'b0;
      f1       <= 1'b0;
      l1       <= 1'b0;
      d1       <= 1'b0;
      PixValid <= 1'b0;
      Frame    <= 1'b0;
      Line     <= 1'b0;
      Done     <= 1'b0;
      Pixel    <= '0;
    end else begin
      v1       <= scan;
      f1       <= scan && first_frame;
      l1       <= scan && first_line;
      d1       <= scan && last_pix;
      PixValid <= v1;
      Frame    <= f1;
      Line     <= l1;
      Done     <= d1;
      Pixel    <= v1 ? pix_src : '0;
    end
  end
endmodule

// File: tb/tb_raster_stream_gen.sv
`timescale 1ns/1ps
module tb_raster_stream_gen;
  localparam int W = 4;
  localparam int H = 3;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Start = 1'b0;
  logic        Continuous = 1'b0;
`ifdef RASTER_TESTPAT_EN
  logic        TestMode = 1'b0;
`endif
  logic        Busy, Done, RdEn, Frame, Line, PixValid;
  logic [7:0]  RdX, RdY;
  logic [10:0] RdData;
  logic [10:0] Pixel;

  raster_stream_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .Start      (Start),
    .Continuous (Continuous),
`ifdef RASTER_TESTPAT_EN
    .TestMode   (TestMode),
`endif
    .Busy       (Busy),
    .Done       (Done),
    .RdEn       (RdEn),
    .RdX        (RdX),
    .RdY        (RdY),
    .RdData     (RdData),
    .Pixel      (Pixel),
    .Frame      (Frame),
    .Line       (Line),
    .PixValid   (PixValid)
  );

  always #5 Clk = ~Clk;

  // Buffer model: data = (y<<8)|x, one cycle after RdEn; junk when not read.
  always @(posedge Clk) RdData <= RdEn ? {RdY[2:0], RdX} : 11'h555;

  typedef struct packed {
    logic        start;
    logic        cont;
    logic        rden;
    logic [7:0]  rdx;
    logic [7:0]  rdy;
    logic        busy;
    logic        pv;
    logic [10:0] pix;
    logic        frm;
    logic        line;
    logic        done;
  } vec_t;

  vec_t vecs[17];
  int   nvec = 0;
  int   nmis = 0;
  int   s_pv, s_done, s_first, s_last, rx, ry;
  int   frm_at[$];

  function automatic vec_t mk(input logic st, input logic ct, input logic re, input int ax, input int ay,
                              input logic bz, input logic pv, input int px, input logic fr,
                              input logic ln, input logic dn);
    vec_t v;
    v = '{st, ct, re, 8'(ax), 8'(ay), bz, pv, 11'(px), fr, ln, dn};
    return v;
  endfunction

  function automatic logic [32:0] obs();
    return {RdEn, RdX, RdY, Busy, PixValid, Pixel, Frame, Line, Done};
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  // Receiver-side column/row tracking plus stream statistics over a fixed window.
  task automatic observe(input int ncyc, input bit drop_cont);
    s_pv = 0; s_done = 0; s_first = -1; s_last = -1; rx = 0; ry = 0;
    frm_at.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
`ifdef RASTER_TESTPAT_EN
      if (TestMode) check("tm_rden", 33'(RdEn), 33'd0);
`endif
      if (PixValid) begin
        s_pv++;
        if (s_first < 0) s_first = c;
        s_last = c;
        check("frame_and_line", 33'(Frame && Line), 33'd0);
        if (Frame) begin
          frm_at.push_back(s_pv);
          rx = 0; ry = 0;
        end else if (Line) begin
          rx = 0; ry++;
        end else begin
          rx++;
        end
        check("rx_pixel", 33'(Pixel), 33'({ry[2:0], rx[7:0]}));
      end else begin
        check("idle_zero", 33'({Pixel, Frame, Line, Done}), 33'd0);
      end
      if (Done) begin
        s_done++;
        check("done_pixel", 33'(Pixel), 33'h203);
        if (drop_cont) begin
          @(posedge Clk); #1 Continuous = 1'b0;
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 'h000, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 1, 0, 'h000, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 1, 0, 'h000, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 2, 0, 1, 1, 'h000, 1, 0, 0);
    vecs[4]  = mk(0, 0, 1, 3, 0, 1, 1, 'h001, 0, 0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 1, 1, 1, 'h002, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 1, 1, 1, 1, 'h003, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 2, 1, 1, 1, 'h100, 0, 1, 0);
    vecs[8]  = mk(0, 0, 1, 3, 1, 1, 1, 'h101, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 2, 1, 1, 'h102, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 2, 1, 1, 'h103, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 2, 2, 1, 1, 'h200, 0, 1, 0);
    vecs[12] = mk(0, 0, 1, 3, 2, 1, 1, 'h201, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 1, 1, 'h202, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 1, 1, 'h203, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 'h000, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 'h000, 0, 0, 0);

    #2 check("reset_state", obs(), 33'd0);
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;

    // Single frame, with Start re-pulsed mid-stream and during drain.
    for (int i = 0; i < 17; i++) begin
      @(posedge Clk); #1;
      Start      = vecs[i].start;
      Continuous = vecs[i].cont;
      @(negedge Clk);
      check($sformatf("tbl[%0d]", i), obs(), vecs[i][32:0]);
    end
    @(posedge Clk); #1 Start = 1'b0;

    // Two continuous frames; Continuous dropped during the second.
    Continuous = 1'b1;
    pulse_start();
    observe(40, 1'b1);
    check("cont_pv", 33'(s_pv), 33'd24);
    check("cont_contig", 33'(s_last - s_first + 1), 33'd24);
    check("cont_done", 33'(s_done), 33'd2);
    check("cont_nframe", 33'(frm_at.size()), 33'd2);
    check("cont_frm0", 33'(frm_at.size() > 0 ? frm_at[0] : -1), 33'd1);
    check("cont_frm1", 33'(frm_at.size() > 1 ? frm_at[1] : -1), 33'd13);

    // Reset at the sixth pixel, then a fresh frame.
    begin
      int  seen;
      bit  hit;
      seen = 0; hit = 1'b0;
      pulse_start();
      for (int c = 0; c < 30 && !hit; c++) begin
        @(negedge Clk);
        if (PixValid) seen++;
        if (seen == 6) hit = 1'b1;
      end
      check("rst_reach", 33'(hit), 33'd1);
      nReset = 1'b0;
      #1 check("rst_outputs", obs(), 33'd0);
      repeat (2) @(posedge Clk);
      #1 nReset = 1'b1;
      observe(6, 1'b0);
      check("rst_no_pv", 33'(s_pv), 33'd0);
      check("rst_no_done", 33'(s_done), 33'd0);
      pulse_start();
      observe(20, 1'b0);
      check("rst_new_pv", 33'(s_pv), 33'd12);
      check("rst_new_done", 33'(s_done), 33'd1);
      check("rst_new_frm", 33'(frm_at.size() > 0 ? frm_at[0] : -1), 33'd1);
    end

`ifdef RASTER_TESTPAT_EN
    TestMode = 1'b1;
    pulse_start();
    observe(20, 1'b0);
    check("tm_pv", 33'(s_pv), 33'd12);
    check("tm_done", 33'(s_done), 33'd1);
    TestMode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
